// File: rtl/group_event_encoder.sv
`default_nettype none
// ============================================================================
// group_event_encoder - round-robin group grant, pixel capture, event FIFO
// Revision: 1.0
// ============================================================================
module group_event_encoder #(
   parameter  int Lvl_ROWS   = 4,
   parameter  int Lvl_COLS   = 4,
   parameter  int Lvl0_ADD   = 2,
   parameter  int FIFO_DEPTH = 32,
   parameter  int TIMEOUT    = 64,
   localparam int GRP_PIX    = 2**(2*Lvl0_ADD),
   localparam int GR_ADD     = $clog2(Lvl_ROWS),
   localparam int GC_ADD     = $clog2(Lvl_COLS)
) (
   input  logic                                clk_i,
   input  logic                                reset_i,
   input  logic [Lvl_ROWS-1:0][Lvl_COLS-1:0]   req_i,
   input  logic                                active_i,
   input  logic [Lvl0_ADD-1:0]                 x_add_i,
   input  logic [Lvl0_ADD-1:0]                 y_add_i,
   input  logic                                grp_release_i,
   output logic [Lvl_ROWS-1:0][Lvl_COLS-1:0]   enable_o,
   output logic                                event_valid_o,
   input  logic                                event_ready_i,
   output logic [GR_ADD+Lvl0_ADD-1:0]          event_x_o,
   output logic [GC_ADD+Lvl0_ADD-1:0]          event_y_o,
   output logic                                busy_o,
   output logic                                overflow_o,
   output logic                                timeout_o
);

   localparam int c_NUM_GRP = Lvl_ROWS * Lvl_COLS;
   localparam int c_IDX_W   = (c_NUM_GRP > 1) ? $clog2(c_NUM_GRP) : 1;
   localparam int c_FA_W    = $clog2(FIFO_DEPTH);
   localparam int c_WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int c_DW      = GR_ADD + GC_ADD + 2 * Lvl0_ADD;
   localparam logic [c_FA_W:0] c_MAX_FILL = (c_FA_W+1)'(FIFO_DEPTH - GRP_PIX);

   typedef enum logic [0:0] { IDLE = 1'b0, GRANT = 1'b1 } state_t;

   state_t                r_state;
   logic [c_IDX_W-1:0]    r_rr_ptr;
   logic [c_IDX_W-1:0]    r_win;
   logic [c_NUM_GRP-1:0]  r_enable;
   logic [c_WD_W-1:0]     r_wd_cnt;
   logic [c_FA_W:0]       r_wr_ptr;
   logic [c_FA_W:0]       r_rd_ptr;
   logic [c_DW-1:0]       r_mem [FIFO_DEPTH];
   logic                  r_overflow;

   logic [c_NUM_GRP-1:0]  w_req_flat;
   logic                  w_found;
   logic [c_IDX_W-1:0]    w_pick;
   logic [c_IDX_W-1:0]    w_next_ptr;
   logic [GR_ADD-1:0]     w_win_row;
   logic [GC_ADD-1:0]     w_win_col;
   logic [c_DW-1:0]       w_din;
   logic [c_FA_W:0]       w_count;
   logic                  w_space;
   logic                  w_empty;
   logic                  w_full;
   logic                  w_push_req;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_drop;
   logic                  w_timeout;
   logic                  w_release;

   assign w_req_flat = req_i;

   // First requester at or after rr_ptr, wrapping over the row-major index space.
   always_comb begin
      w_found = 1'b0;
      w_pick  = r_rr_ptr;
      for (int i = 0; i < c_NUM_GRP; i++) begin
         if (!w_found && w_req_flat[c_IDX_W'((int'(r_rr_ptr) + i) % c_NUM_GRP)]) begin
            w_found = 1'b1;
            w_pick  = c_IDX_W'((int'(r_rr_ptr) + i) % c_NUM_GRP);
         end
      end
   end

   assign w_next_ptr = c_IDX_W'((int'(r_win) + 1) % c_NUM_GRP);
   assign w_win_row  = GR_ADD'(int'(r_win) / Lvl_COLS);
   assign w_win_col  = GC_ADD'(int'(r_win) % Lvl_COLS);
   assign w_din      = {w_win_row, x_add_i, w_win_col, y_add_i};

   assign w_count    = r_wr_ptr - r_rd_ptr;
   assign w_space    = (w_count <= c_MAX_FILL);
   assign w_empty    = (r_wr_ptr == r_rd_ptr);
   assign w_full     = (r_wr_ptr[c_FA_W] != r_rd_ptr[c_FA_W]) &&
                       (r_wr_ptr[c_FA_W-1:0] == r_rd_ptr[c_FA_W-1:0]);
   assign w_push_req = (r_state == GRANT) && active_i;
   assign w_pop      = !w_empty && event_ready_i;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_push     = w_push_req && (!w_full || w_pop);
   assign w_drop     = w_push_req && w_full && !w_pop;

   assign w_timeout  = (r_state == GRANT) && !grp_release_i && !active_i &&
                       (r_wd_cnt == c_WD_W'(TIMEOUT - 1));
   assign w_release  = (r_state == GRANT) && (grp_release_i || w_timeout);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state  <= IDLE;
         r_rr_ptr <= '0;
         r_win    <= '0;
         r_enable <= '0;
         r_wd_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_wd_cnt <= '0;
               if (w_found && w_space) begin
                  r_win    <= w_pick;
                  r_enable <= c_NUM_GRP'(1) << w_pick;
                  r_state  <= GRANT;
               end
            end
            GRANT: begin
               if (w_release) begin
                  r_enable <= '0;
                  r_rr_ptr <= w_next_ptr;
                  r_wd_cnt <= '0;
                  r_state  <= IDLE;
               end else if (active_i) begin
                  r_wd_cnt <= '0;
               end else begin
                  r_wd_cnt <= r_wd_cnt + c_WD_W'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + (c_FA_W+1)'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + (c_FA_W+1)'(1);
         if (w_drop) r_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr[c_FA_W-1:0]] <= w_din;
   end

   assign enable_o               = r_enable;
   assign busy_o                 = (r_state == GRANT);
   assign overflow_o             = r_overflow;
   assign timeout_o              = w_timeout;
   assign event_valid_o          = !w_empty;
   assign {event_x_o, event_y_o} = w_empty ? '0 : r_mem[r_rd_ptr[c_FA_W-1:0]];

endmodule
`default_nettype wire

// File: tb/tb_group_event_encoder.sv
`default_nettype none
// tb_group_event_encoder - directed steps; expected {x,y} events queued at drive time,
// popped and compared whenever the DUT hands an event downstream.
module tb_group_event_encoder;

   logic             clk_i;
   logic             reset_i;
   logic [3:0][3:0]  req;
   logic             active;
   logic [1:0]       xa;
   logic [1:0]       ya;
   logic             rel;
   logic [3:0][3:0]  enable;
   logic             valid;
   logic             rdy;
   logic [3:0]       ex;
   logic [3:0]       ey;
   logic             busy;
   logic             ovf;
   logic             tmo;

   int               n_pass  = 0;
   int               n_total = 0;
   int               pops    = 0;
   logic [7:0]       sb [$];

   group_event_encoder dut (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .req_i         (req),
      .active_i      (active),
      .x_add_i       (xa),
      .y_add_i       (ya),
      .grp_release_i (rel),
      .enable_o      (enable),
      .event_valid_o (valid),
      .event_ready_i (rdy),
      .event_x_o     (ex),
      .event_y_o     (ey),
      .busy_o        (busy),
      .overflow_o    (ovf),
      .timeout_o     (tmo)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // One pixel from group g; queued as {row, x, col, y} when it should be stored.
   task automatic pix(input int g, input int x, input int y, input bit r, input bit store);
      active = 1'b1;
      xa     = 2'(x);
      ya     = 2'(y);
      rel    = r;
      if (store) sb.push_back({2'(g / 4), 2'(x), 2'(g % 4), 2'(y)});
      cyc();
      active = 1'b0;
      rel    = 1'b0;
   endtask

   task automatic wait_grant(input int idx, input string tag);
      int n = 0;
      while (enable == '0 && n < 40) begin
         cyc();
         n++;
      end
      chk(tag, 32'(enable), 32'(1) << idx);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      rdy = 1'b1;
      while (valid && n < 100) begin
         cyc();
         n++;
      end
      rdy = 1'b0;
      chk(tag, 32'(valid), 32'(0));
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'(0));
   endtask

   always @(negedge clk_i) begin
      logic [7:0] exp_ev;
      if (!reset_i && valid && rdy) begin
         if (sb.size() != 0) exp_ev = sb.pop_front();
         else                exp_ev = 'x;
         chk("event_xy", 32'({ex, ey}), 32'(exp_ev));
         pops++;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int  order [4] = '{0, 5, 0, 5};
      bit  early;
      int  p0;

      reset_i = 1'b1;
      req     = '0;
      active  = 1'b0;
      xa      = '0;
      ya      = '0;
      rel     = 1'b0;
      rdy     = 1'b0;
      repeat (3) cyc();
      chk("rst_enable",   32'(enable), 32'(0));
      chk("rst_busy",     32'(busy),   32'(0));
      chk("rst_valid",    32'(valid),  32'(0));
      chk("rst_overflow", 32'(ovf),    32'(0));
      chk("rst_timeout",  32'(tmo),    32'(0));
      chk("rst_xy",       32'({ex, ey}), 32'(0));
      reset_i = 1'b0;
      cyc();

      // Single pixel from group (1,2)
      req = 16'b1 << 6;
      cyc();
      chk("single_grant", 32'(enable), 32'(1) << 6);
      chk("single_busy",  32'(busy),   32'(1));
      req = '0;
      pix(6, 3, 1, 1'b1, 1'b1);
      chk("single_enable_drop", 32'(enable), 32'(0));
      chk("single_valid",       32'(valid),  32'(1));
      chk("single_x",           32'(ex),     32'(7));
      chk("single_y",           32'(ey),     32'(9));
      rdy = 1'b1;
      cyc();
      chk("single_popped", 32'(valid), 32'(0));

      // Round-robin between groups 0 and 5
      req = (16'b1 << 0) | (16'b1 << 5);
      for (int j = 0; j < 4; j++) begin
         wait_grant(order[j], "rr_grant");
         pix(order[j], j, 1, 1'b0, 1'b1);
         if (j == 3) req = '0;
         pix(order[j], j, 2, 1'b1, 1'b1);
         chk("rr_gap", 32'(enable), 32'(0));
      end
      cyc();
      cyc();
      chk("rr_drained", 32'(valid), 32'(0));

      // Backpressure: 17 buffered events block the next grant
      rdy = 1'b0;
      req = 16'b1 << 6;
      wait_grant(6, "bp_grant");
      req = '0;
      for (int k = 0; k < 17; k++) pix(6, k % 4, (k / 4) % 4, k == 16, 1'b1);
      req = 16'b1 << 7;
      repeat (4) cyc();
      chk("bp_hold_enable", 32'(enable), 32'(0));
      chk("bp_hold_busy",   32'(busy),   32'(0));
      rdy = 1'b1;
      cyc();
      rdy = 1'b0;
      wait_grant(7, "bp_regrant");
      chk("bp_no_overflow", 32'(ovf), 32'(0));
      req = '0;
      rel = 1'b1;
      cyc();
      rel = 1'b0;
      drain("bp_drain");

      // Full FIFO: simultaneous push/pop, then a dropped push
      req = 16'b1 << 9;
      wait_grant(9, "full_grant");
      req = '0;
      for (int k = 0; k < 32; k++) pix(9, k % 4, (k / 4) % 4, 1'b0, 1'b1);
      chk("full_valid",  32'(valid), 32'(1));
      chk("full_no_ovf", 32'(ovf),   32'(0));
      rdy = 1'b1;
      pix(9, 0, 0, 1'b0, 1'b1);
      rdy = 1'b0;
      chk("full_pushpop_no_ovf", 32'(ovf), 32'(0));
      pix(9, 1, 0, 1'b0, 1'b0);
      chk("full_drop_ovf", 32'(ovf), 32'(1));
      rel = 1'b1;
      cyc();
      rel = 1'b0;
      p0 = pops;
      drain("full_drain");
      chk("full_drain_count", 32'(pops - p0), 32'(32));
      chk("ovf_sticky",       32'(ovf),       32'(1));

      // Watchdog release of an idle group
      req = 16'b1 << 3;
      wait_grant(3, "to_grant");
      req = '0;
      early = 1'b0;
      for (int k = 0; k < 63; k++) begin
         if (tmo !== 1'b0) early = 1'b1;
         cyc();
      end
      chk("to_no_early",    32'(early),  32'(0));
      chk("to_pulse",       32'(tmo),    32'(1));
      chk("to_enable_held", 32'(enable), 32'(1) << 3);
      cyc();
      chk("to_enable_clr", 32'(enable), 32'(0));
      chk("to_pulse_end",  32'(tmo),    32'(0));
      req = (16'b1 << 3) | (16'b1 << 4);
      wait_grant(4, "to_rr_advanced");
      req = '0;
      rel = 1'b1;
      cyc();
      rel = 1'b0;

      // Reset while a group is granted with queued events
      req = 16'b1 << 10;
      wait_grant(10, "mid_grant");
      req = '0;
      for (int k = 0; k < 3; k++) pix(10, k, k, 1'b0, 1'b1);
      chk("mid_busy",  32'(busy),  32'(1));
      chk("mid_valid", 32'(valid), 32'(1));
      reset_i = 1'b1;
      cyc();
      chk("mid_rst_enable",   32'(enable),   32'(0));
      chk("mid_rst_busy",     32'(busy),     32'(0));
      chk("mid_rst_valid",    32'(valid),    32'(0));
      chk("mid_rst_overflow", 32'(ovf),      32'(0));
      chk("mid_rst_timeout",  32'(tmo),      32'(0));
      chk("mid_rst_xy",       32'({ex, ey}), 32'(0));
      sb.delete();
      reset_i = 1'b0;
      req = (16'b1 << 0) | (16'b1 << 10);
      wait_grant(0, "post_rst_rr0");
      req = '0;
      rel = 1'b1;
      cyc();
      rel = 1'b0;
      cyc();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
